riscv_mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline stage that replaces the fixed stall-vector register with a valid/ready handshake, a 1- or 2-entry skid buffer, a flush input and optional performance counters. It sits between the memory-access stage and register write-back. It carries destination register index, write enable, data address, read flag and write-back data. Invalid slots present as bubbles with `rd_we_o` = 0, so write-back never fires spuriously.

---
 rtl/riscv_mem_wb_stage_pkg.sv | 15 +
 rtl/riscv_pipe_fifo.sv | 72 +++++++
 rtl/riscv_mem_wb_stage.sv | 87 ++++++++
 tb/tb_riscv_mem_wb_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_wb_stage_pkg.sv
// Shared widths for the MEM/WB stage and the packed payload width helper.
package riscv_mem_wb_stage_pkg;

    localparam int RegAddrBus = 5;
    localparam int MemAddrBus = 32;
    localparam int DataBus    = 32;

    // Payload order is {rd_idx, rd_we, data_addr, data_re, wb_data}
    function automatic int mem_wb_payload_w(input int reg_aw, input int addr_w, input int data_w);
        return reg_aw + 1 + addr_w + 1 + data_w;
    endfunction

    localparam int MemWbPayloadW = mem_wb_payload_w(RegAddrBus, MemAddrBus, DataBus);

endpackage

// File: rtl/riscv_pipe_fifo.sv
// Generic 1- or 2-entry valid/ready skid buffer with flush; head entry is always the oldest.
module riscv_pipe_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   occ_q;
    logic         push;
    logic         pop;

    generate
        if (DEPTH == 2) begin : g_depth2
            assign in_ready = (occ_q < 2'd2);
        end else if (DEPTH == 1) begin : g_depth1
            // Pass-through ready lets a full single slot swap entries every cycle
            assign in_ready = (occ_q == 2'd0) || out_ready;
        end else begin : g_bad_depth
            $error("riscv_pipe_fifo: DEPTH must be 1 or 2");
        end
    endgenerate

    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = head_q;
    assign occ       = occ_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            occ_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_wb_stage.sv
// MEM/WB pipeline stage: packs the payload into riscv_pipe_fifo and zero-masks bubbles.
// Optional stall/bubble counters are built when RISCV_MEMWB_PERF_EN is defined.
module riscv_mem_wb_stage
    import riscv_mem_wb_stage_pkg::*;
#(
    parameter int REG_AW = RegAddrBus,
    parameter int ADDR_W = MemAddrBus,
    parameter int DATA_W = DataBus,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rd_idx_i,
    input  logic              rd_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic              data_re_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] rd_idx_o,
    output logic              rd_we_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_re_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam int PW = mem_wb_payload_w(REG_AW, ADDR_W, DATA_W);

    logic [PW-1:0] in_payload;
    logic [PW-1:0] head_payload;
    logic [PW-1:0] out_payload;

    assign in_payload = {rd_idx_i, rd_we_i, data_addr_i, data_re_i, wb_data_i};

    riscv_pipe_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_payload),
        .occ       (occ_o)
    );

    // Bubbles must never present rd_we_o=1 to the register file
    assign out_payload = head_payload & {PW{out_valid}};
    assign {rd_idx_o, rd_we_o, data_addr_o, data_re_o, wb_data_o} = out_payload;

`ifdef RISCV_MEMWB_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready) stall_q <= sat_inc(stall_q);
            if (!out_valid)              bubble_q <= sat_inc(bubble_q);
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_mem_wb_stage.sv
// Directed bench for riscv_mem_wb_stage (DEPTH=2 and DEPTH=1/CNT_W=2 instances) against a queue model.
module tb_riscv_mem_wb_stage;

    typedef struct packed {
        logic [4:0]  rd_idx;
        logic        rd_we;
        logic [31:0] addr;
        logic        re;
        logic [31:0] data;
    } pl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    logic iv2 = 1'b0, or2 = 1'b0, ir2, ov2;
    pl_t  pi2 = '0;
    logic [4:0] rdo2; logic we2; logic [31:0] addr2; logic re2; logic [31:0] wbo2;
    logic [1:0] occ2; logic [31:0] st2, bu2;

    logic iv1 = 1'b0, or1 = 1'b0, ir1, ov1;
    pl_t  pi1 = '0;
    logic [4:0] rdo1; logic we1; logic [31:0] addr1; logic re1; logic [31:0] wbo1;
    logic [1:0] occ1; logic [1:0] st1, bu1;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    riscv_mem_wb_stage #(.DEPTH(2), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv2), .in_ready(ir2),
        .rd_idx_i(pi2.rd_idx), .rd_we_i(pi2.rd_we), .data_addr_i(pi2.addr),
        .data_re_i(pi2.re), .wb_data_i(pi2.data), .out_valid(ov2), .out_ready(or2),
        .rd_idx_o(rdo2), .rd_we_o(we2), .data_addr_o(addr2), .data_re_o(re2),
        .wb_data_o(wbo2), .occ_o(occ2), .stall_cnt_o(st2), .bubble_cnt_o(bu2)
    );

    riscv_mem_wb_stage #(.DEPTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(ir1),
        .rd_idx_i(pi1.rd_idx), .rd_we_i(pi1.rd_we), .data_addr_i(pi1.addr),
        .data_re_i(pi1.re), .wb_data_i(pi1.data), .out_valid(ov1), .out_ready(or1),
        .rd_idx_o(rdo1), .rd_we_o(we1), .data_addr_o(addr1), .data_re_o(re1),
        .wb_data_o(wbo1), .occ_o(occ1), .stall_cnt_o(st1), .bubble_cnt_o(bu1)
    );

    function automatic pl_t mk(input int idx, input logic we, input logic [31:0] a,
                               input logic re, input logic [31:0] d);
        pl_t p;
        p.rd_idx = idx[4:0];
        p.rd_we  = we;
        p.addr   = a;
        p.re     = re;
        p.data   = d;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an ordered queue per instance plus plain cycle counters
    pl_t q2[$];
    pl_t q1[$];
    int  sz2, sz1;
    int  ms2 = 0, mb2 = 0, ms1 = 0, mb1 = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q2.delete(); q1.delete();
            ms2 = 0; mb2 = 0; ms1 = 0; mb1 = 0;
        end else begin
            sz2 = q2.size();
            sz1 = q1.size();
            if (sz2 == 0) mb2++;
            else if (!or2) ms2++;
            if (sz1 == 0) begin
                if (mb1 < 3) mb1++;
            end else if (!or1) begin
                if (ms1 < 3) ms1++;
            end
            if (flush) begin
                q2.delete(); q1.delete();
            end else begin
                if (sz2 > 0 && or2) q2.delete(0);
                if (iv2 && sz2 < 2) q2.push_back(pi2);
                if (sz1 > 0 && or1) q1.delete(0);
                if (iv1 && (sz1 == 0 || or1)) q1.push_back(pi1);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("d2_valid", ov2, q2.size() != 0);
        chk("d2_payload", {rdo2, we2, addr2, re2, wbo2}, (q2.size() != 0) ? q2[0] : '0);
        chk("d2_occ", occ2, q2.size());
        chk("d2_ready", ir2, q2.size() < 2);
        chk("d1_valid", ov1, q1.size() != 0);
        chk("d1_payload", {rdo1, we1, addr1, re1, wbo1}, (q1.size() != 0) ? q1[0] : '0);
        chk("d1_occ", occ1, q1.size());
        chk("d1_ready", ir1, (q1.size() == 0) || or1);
`ifdef RISCV_MEMWB_PERF_EN
        chk("d2_stall", st2, ms2);
        chk("d2_bubble", bu2, mb2);
        chk("d1_stall", st1, ms1[1:0]);
        chk("d1_bubble", bu1, mb1[1:0]);
`else
        chk("d2_stall", st2, 0);
        chk("d2_bubble", bu2, 0);
        chk("d1_stall", st1, 0);
        chk("d1_bubble", bu1, 0);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", ir2, 1);
        chk("rst_valid", ov2, 0);
        rst = 1'b1;

        // Single push, seen for one cycle then a bubble
        pi2 = mk(5, 1, 32'h1000, 0, 32'hDEADBEEF); iv2 = 1; or2 = 1;
        @(negedge clk); iv2 = 0;
        chk("t1_valid", ov2, 1);
        chk("t1_idx", rdo2, 5);
        chk("t1_we", we2, 1);
        chk("t1_addr", addr2, 32'h1000);
        chk("t1_data", wbo2, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_bub_valid", ov2, 0);
        chk("t1_bub_we", we2, 0);
        chk("t1_bub_data", wbo2, 0);

        // DEPTH=2 back-pressure: A, B accepted, C held off
        or2 = 0; iv2 = 1; pi2 = mk(1, 1, 32'h100, 1, 32'hA);
        @(negedge clk); pi2 = mk(2, 1, 32'h104, 0, 32'hB);
        @(negedge clk); pi2 = mk(3, 0, 32'h108, 1, 32'hC);
        chk("t2_ready_low", ir2, 0);
        @(negedge clk);
        chk("t2_occ2", occ2, 2);
        chk("t2_head_a", rdo2, 1);
        or2 = 1;
        @(negedge clk);
        chk("t2_head_b", rdo2, 2);
        chk("t2_occ1", occ2, 1);
        @(negedge clk); iv2 = 0;
        chk("t2_head_c", rdo2, 3);
        @(negedge clk);
        chk("t2_empty", ov2, 0);

        // DEPTH=1 full, streaming 8 entries with no bubbles
        or2 = 0;
        iv1 = 1; or1 = 0; pi1 = mk(0, 1, 32'h0, 0, 32'h1000_0000);
        @(negedge clk);
        chk("t3_ready_full", ir1, 0);
        or1 = 1;
        for (int k = 1; k <= 8; k++) begin
            pi1 = mk(k, 1, k * 4, 0, 32'h1000_0000 + k);
            @(negedge clk);
            chk("t3_stream_valid", ov1, 1);
            chk("t3_stream_idx", rdo1, k);
        end
        iv1 = 0;
        @(negedge clk);
        chk("t3_drained", ov1, 0);

        // Flush at occ=2 with a pending push, then at occ=1 with an acceptable push
        iv2 = 1; pi2 = mk(7, 1, 32'h200, 0, 32'h77);
        @(negedge clk); pi2 = mk(8, 1, 32'h204, 0, 32'h88);
        @(negedge clk);
        flush = 1; pi2 = mk(9, 1, 32'h208, 1, 32'h99);
        @(negedge clk); flush = 0;
        chk("t4_occ0", occ2, 0);
        chk("t4_valid0", ov2, 0);
        pi2 = mk(10, 1, 32'h20C, 0, 32'hAA);
        @(negedge clk);
        flush = 1; pi2 = mk(11, 1, 32'h210, 0, 32'hBB);
        @(negedge clk); flush = 0; iv2 = 0; or2 = 1;
        chk("t4b_occ0", occ2, 0);
        repeat (2) @(negedge clk);
        chk("t4b_no_ghost", ov2, 0);

        // Asynchronous reset mid-stream at occ=2
        or2 = 0; iv2 = 1; pi2 = mk(12, 1, 32'h300, 0, 32'hC0);
        @(negedge clk); pi2 = mk(13, 1, 32'h304, 1, 32'hC1);
        @(negedge clk); iv2 = 0;
        chk("t5_pre_occ", occ2, 2);
        #2 rst = 1'b0;
        #1;
        chk("t5_valid", ov2, 0);
        chk("t5_we", we2, 0);
        chk("t5_data", wbo2, 0);
        chk("t5_ready", ir2, 1);
        chk("t5_occ", occ2, 0);
        chk("t5_stall", st2, 0);
        chk("t5_bubble", bu2, 0);

        // Counter scenario: 1 bubble (push), 3 stalls, 1 pop, 3 more bubbles
        @(negedge clk);
        rst = 1'b1; iv2 = 1; or2 = 0; pi2 = mk(14, 1, 32'h400, 0, 32'hD0);
        @(negedge clk); iv2 = 0;
        repeat (3) @(negedge clk);
        or2 = 1;
        repeat (4) @(negedge clk);
`ifdef RISCV_MEMWB_PERF_EN
        chk("t6_stall3", st2, 3);
        chk("t6_bubble4", bu2, 4);
        chk("t6_sat3", bu1, 3);
`else
        chk("t6_stall_off", st2, 0);
        chk("t6_bubble_off", bu1, 0);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
